// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// mem_pkg : width codes, entry/state types and size/extend helpers
// Rev 1.0
// ============================================================================
package mem_pkg;

    localparam logic [2:0] WB  = 3'b000;
    localparam logic [2:0] WH  = 3'b001;
    localparam logic [2:0] WW  = 3'b010;
    localparam logic [2:0] WBU = 3'b100;
    localparam logic [2:0] WHU = 3'b101;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [2:0]  width;
        logic [31:0] data;
    } entry_t;

    function automatic logic [2:0] size_of(input logic [2:0] width);
        case (width)
            WB, WBU: size_of = 3'd1;
            WH, WHU: size_of = 3'd2;
            default: size_of = 3'd4;
        endcase
    endfunction

    function automatic logic legal_width(input logic [2:0] width);
        case (width)
            WB, WH, WW, WBU, WHU: legal_width = 1'b1;
            default:              legal_width = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] data, input logic [2:0] width);
        case (width)
            WB:      extend = {{24{data[7]}}, data[7:0]};
            WH:      extend = {{16{data[15]}}, data[15:0]};
            WBU:     extend = {24'h0, data[7:0]};
            WHU:     extend = {16'h0, data[15:0]};
            default: extend = data;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_fifo.sv
`default_nettype none
// ============================================================================
// store_fifo : in-order store queue, compare bus presented oldest-first
// Rev 1.0
// ============================================================================
module store_fifo import mem_pkg::*; #(
    parameter int DEPTH    = 4,
    parameter int CACHE_AW = 6
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               push,
    input  entry_t                             push_entry,
    input  logic                               pop,
    output entry_t                             head,
    output logic [$clog2(DEPTH):0]             count,
    output logic [DEPTH-1:0]                   cmp_valid,
    output logic [DEPTH-1:0][CACHE_AW-1:0]     cmp_addr,
    output logic [DEPTH-1:0][2:0]              cmp_width,
    output logic [DEPTH-1:0][31:0]             cmp_data
);

    localparam int PW = $clog2(DEPTH);

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [PW:0]     r_count;

    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= push_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign head  = r_mem[r_rd_ptr];
    assign count = r_count;

    // Slot k of the compare bus is the k-th oldest entry, so a higher k is younger.
    for (genvar k = 0; k < DEPTH; k++) begin : g_cmp
        logic [PW-1:0] w_slot;
        assign w_slot       = r_rd_ptr + PW'(k);
        assign cmp_valid[k] = ((PW+1)'(k) < r_count);
        assign cmp_addr[k]  = r_mem[w_slot].addr[CACHE_AW-1:0];
        assign cmp_width[k] = r_mem[w_slot].width;
        assign cmp_data[k]  = r_mem[w_slot].data;
    end

endmodule
`default_nettype wire

// File: rtl/store_buffer.sv
`default_nettype none
// ============================================================================
// store_buffer : store queue in front of the D-cache with load forwarding/flush
// Rev 1.0
// ============================================================================
module store_buffer import mem_pkg::*; #(
    parameter int DEPTH    = 4,
    parameter int CACHE_AW = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_width,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        req_err,
    input  logic        flush_req,
    output logic        flush_done,
    output logic        empty,
    output logic        cache_write_en,
    output logic [2:0]  cache_width,
    output logic [32:0] cache_address,
    output logic [31:0] cache_in,
    input  logic [31:0] cache_out
);

    localparam int PW = $clog2(DEPTH);

    entry_t                          w_head;
    entry_t                          w_push_entry;
    logic [PW:0]                     w_count;
    logic [DEPTH-1:0]                w_cmp_valid;
    logic [DEPTH-1:0][CACHE_AW-1:0]  w_cmp_addr;
    logic [DEPTH-1:0][2:0]           w_cmp_width;
    logic [DEPTH-1:0][31:0]          w_cmp_data;

    logic [CACHE_AW-1:0] w_la;
    logic [2:0]          w_ls;
    logic [DEPTH-1:0]    w_ov;
    logic                w_hit;
    logic [PW-1:0]       w_young;
    logic                w_same, w_legal, w_stall, w_run;
    logic                w_accept, w_push, w_load, w_read, w_fwd, w_pop;

    state_t      r_state;
    logic        r_flush_done;
    logic        r_resp_valid, r_resp_cache, r_req_err;
    logic [2:0]  r_resp_width;
    logic [31:0] r_fwd_data;
    logic        r_wen;
    logic [2:0]  r_cwidth;
    logic [32:0] r_caddr;
    logic [31:0] r_cin;

    assign w_push_entry = {req_address, req_width, req_wdata};

    store_fifo #(.DEPTH(DEPTH), .CACHE_AW(CACHE_AW)) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (w_push),
        .push_entry (w_push_entry),
        .pop        (w_pop),
        .head       (w_head),
        .count      (w_count),
        .cmp_valid  (w_cmp_valid),
        .cmp_addr   (w_cmp_addr),
        .cmp_width  (w_cmp_width),
        .cmp_data   (w_cmp_data)
    );

    assign w_la = req_address[CACHE_AW-1:0];
    assign w_ls = size_of(req_width);

    // Two byte ranges overlap (modulo the cache space) iff one start lies inside the other.
    for (genvar k = 0; k < DEPTH; k++) begin : g_ov
        logic [CACHE_AW-1:0] w_d_el, w_d_le;
        assign w_d_el  = w_cmp_addr[k] - w_la;
        assign w_d_le  = w_la - w_cmp_addr[k];
        assign w_ov[k] = w_cmp_valid[k] &&
                         ((w_d_el < CACHE_AW'(w_ls)) ||
                          (w_d_le < CACHE_AW'(size_of(w_cmp_width[k]))));
    end

    always_comb begin
        w_hit   = 1'b0;
        w_young = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (w_ov[k]) begin
                w_hit   = 1'b1;
                w_young = PW'(k);
            end
        end
    end

    assign w_same   = (w_cmp_addr[w_young] == w_la) && (size_of(w_cmp_width[w_young]) == w_ls);
    assign w_legal  = legal_width(req_width) && !(req_write && req_width[2]);
    assign w_stall  = !req_write && w_legal && w_hit && !w_same;
    assign w_run    = (r_state == ST_RUN) && !flush_req;
    assign req_ready = w_run && !w_stall;

    assign w_accept = req_valid && req_ready;
    assign w_push   = w_accept && req_write && w_legal;
    assign w_load   = w_accept && !req_write && w_legal;
    assign w_read   = w_load && !w_hit;
    assign w_fwd    = w_load && w_hit;
    // The port is free unless a load is reading the cache this cycle.
    assign w_pop    = !w_read && (w_count != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_valid <= 1'b0;
            r_resp_cache <= 1'b0;
            r_resp_width <= WW;
            r_fwd_data   <= '0;
            r_req_err    <= 1'b0;
            r_wen        <= 1'b1;
            r_cwidth     <= WW;
            r_caddr      <= '0;
            r_cin        <= '0;
        end else begin
            r_resp_valid <= w_load;
            r_resp_cache <= w_read;
            r_req_err    <= w_accept && !w_legal;
            if (w_load) r_resp_width <= req_width;
            if (w_fwd)  r_fwd_data   <= extend(w_cmp_data[w_young], req_width);
            r_wen <= 1'b1;
            if (w_read) begin
                r_cwidth <= req_width;
                r_caddr  <= {1'b0, req_address};
            end else if (w_pop) begin
                r_wen    <= 1'b0;
                r_cwidth <= w_head.width;
                r_caddr  <= {1'b0, w_head.addr};
                r_cin    <= w_head.data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_flush_done <= 1'b0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                ST_RUN: begin
                    if (flush_req) begin
                        if (w_count == '0) begin
                            r_state      <= ST_DONE;
                            r_flush_done <= 1'b1;
                        end else begin
                            r_state <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    if (w_count == '0) begin
                        r_state      <= ST_DONE;
                        r_flush_done <= 1'b1;
                    end
                end
                ST_DONE:  r_state <= ST_RUN;
                default:  r_state <= ST_RUN;
            endcase
        end
    end

    // Cache read data is valid in the cycle after the read address is registered.
    assign resp_rdata     = r_resp_cache ? extend(cache_out, r_resp_width) : r_fwd_data;
    assign resp_valid     = r_resp_valid;
    assign req_err        = r_req_err;
    assign flush_done     = r_flush_done;
    assign empty          = (w_count == '0);
    assign cache_write_en = r_wen;
    assign cache_width    = r_cwidth;
    assign cache_address  = r_caddr;
    assign cache_in       = r_cin;

endmodule
`default_nettype wire
